// File: rtl/hub75_scan_if.sv
// hub75_scan_if: pixel RAM read port and HUB75 panel lines of the scan engine
//   ram_raddr  {row, col} read address        (master -> slave)
//   ram_rdata  {upper, lower} pixel pair      (slave -> master), 1 cycle after ram_raddr
//   hub_clk / hub_lat / hub_oe                panel shift clock, latch, active-low enable
//   hub_addr   displayed row
//   hub_rgb    {r1, g1, b1, r2, g2, b2}
interface hub75_scan_if #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 5,
  parameter int PIX_BITS = 16
);
  logic [ROW_BITS+COL_BITS-1:0] ram_raddr;
  logic [2*PIX_BITS-1:0]        ram_rdata;
  logic                         hub_clk;
  logic                         hub_lat;
  logic                         hub_oe;
  logic [ROW_BITS-1:0]          hub_addr;
  logic [5:0]                   hub_rgb;
  modport master (output ram_raddr, hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb, input ram_rdata);
  modport slave (input ram_raddr, hub_clk, hub_lat, hub_oe, hub_addr, hub_rgb, output ram_rdata);
endinterface

// File: rtl/hub75_scan.sv
// hub75_scan: HUB75 scan engine, row/column walk with pixel prefetch and subframe PWM
//   clock, resetn   system clock, synchronous active-low reset
//   enable          run scan, sampled at row boundaries
//   brightness      on-time in columns, captured at frame_start (only with HUB75_BRIGHTNESS_EN)
//   bus             hub75_scan_if master: RAM read address/data and panel lines
//   frame_start     1-cycle pulse when row 0 of subframe 0 begins
//   busy            high whenever the engine is not idle
module hub75_scan #(
  parameter int COLS     = 32,
  parameter int ROW_BITS = 4,
  parameter int PWM_BITS = 5,
  parameter int PIX_BITS = 16,
  parameter int CLK_DIV  = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [$clog2(COLS):0] brightness,
`endif
  hub75_scan_if.master          bus,
  output logic                  frame_start,
  output logic                  busy
);
  localparam int CB = $clog2(COLS);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [CB-1:0] COL_END = CB'(COLS - 1);
  localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = PWM_BITS'(2**PWM_BITS - 2);
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, BLANK, LATCH} state_t;
  state_t                 state_q;
  logic [ROW_BITS-1:0]    row_q, addr_q;
  logic [CB-1:0]          col_q;
  logic [PWM_BITS-1:0]    pwm_q;
  logic [DW-1:0]          div_q;
  logic                   hi_q, latched_q, clk_q, lat_q, oe_q, fs_q, busy_q;
  logic [ROW_BITS+CB-1:0] raddr_q;
  logic [5:0]             rgb_q, rgb_d;
  logic                   fs_d, oe_fetch, oe_col;
  logic                   unused_rdata;
  assign unused_rdata = ^bus.ram_rdata;
  // bit i of rgb: i/3 picks lower/upper half, i%3 picks B/G/R field
  always_comb begin
    rgb_d = '0;
    for (int i = 0; i < 6; i++)
      rgb_d[i] = bus.ram_rdata[(i / 3) * PIX_BITS + (i % 3) * PWM_BITS +: PWM_BITS] > pwm_q;
  end
  assign fs_d = enable && (state_q == IDLE || (state_q == LATCH && row_q == '1 && pwm_q == PWM_MAX));
`ifdef HUB75_BRIGHTNESS_EN
  logic [CB:0] bright_q;
  // at a frame boundary the freshly captured value already governs the first FETCH
  assign oe_fetch = ~|(fs_d ? brightness : bright_q);
  assign oe_col = !(latched_q && ({1'b0, col_q} + (CB + 1)'(1)) < bright_q);
`else
  assign oe_fetch = 1'b0;
  assign oe_col = !latched_q;
`endif
  always_ff @(posedge clock)
    if (!resetn) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      pwm_q <= '0;
      div_q <= '0;
      hi_q <= 1'b0;
      latched_q <= 1'b0;
      raddr_q <= '0;
      rgb_q <= '0;
      clk_q <= 1'b0;
      lat_q <= 1'b0;
      oe_q <= 1'b1;
      addr_q <= '0;
      fs_q <= 1'b0;
      busy_q <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q <= '0;
`endif
    end else begin
      fs_q <= fs_d;
`ifdef HUB75_BRIGHTNESS_EN
      if (fs_d) bright_q <= brightness;
`endif
      case (state_q)
        IDLE: if (enable) begin
          state_q <= FETCH;
          row_q <= '0;
          pwm_q <= '0;
          raddr_q <= '0;
          busy_q <= 1'b1;
        end
        FETCH: state_q <= SHIFT;
        SHIFT: begin
          if (!hi_q && div_q == '0) rgb_q <= rgb_d;
          if (div_q != DIV_END) div_q <= div_q + DW'(1);
          else begin
            div_q <= '0;
            hi_q <= !hi_q;
            clk_q <= !hi_q;
            // prefetch the next column while the panel samples this one
            if (!hi_q && col_q != COL_END) raddr_q <= {row_q, col_q + CB'(1)};
            if (hi_q) begin
              state_q <= col_q == COL_END ? BLANK : SHIFT;
              oe_q <= col_q == COL_END ? 1'b1 : oe_col;
              col_q <= col_q == COL_END ? '0 : col_q + CB'(1);
            end
          end
        end
        BLANK: begin
          state_q <= LATCH;
          lat_q <= 1'b1;
          addr_q <= row_q;
        end
        LATCH: begin
          state_q <= enable ? FETCH : IDLE;
          lat_q <= 1'b0;
          latched_q <= enable;
          busy_q <= enable;
          oe_q <= enable ? oe_fetch : 1'b1;
          row_q <= row_q + ROW_BITS'(1);
          raddr_q <= {row_q + ROW_BITS'(1), CB'(0)};
          if (row_q == '1) pwm_q <= pwm_q == PWM_MAX ? '0 : pwm_q + PWM_BITS'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.ram_raddr = raddr_q;
  assign bus.hub_clk = clk_q;
  assign bus.hub_lat = lat_q;
  assign bus.hub_oe = oe_q;
  assign bus.hub_addr = addr_q;
  assign bus.hub_rgb = rgb_q;
  assign frame_start = fs_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_hub75_scan.sv
// tb_hub75_scan: directed bench for hub75_scan, 4 columns x 2 rows, 2-bit PWM, row period 11 cycles
module tb_hub75_scan;
  logic clock, resetn, enable;
`ifdef HUB75_BRIGHTNESS_EN
  logic [2:0] brightness;
`endif
  logic frame_start, busy;
  int n_cmp, n_bad, k, c, rw, pw, lats, idle_at, lows;
  logic [31:0] mem [8];
  hub75_scan_if #(.ROW_BITS(1), .COL_BITS(2), .PIX_BITS(16)) bus ();
  hub75_scan #(.COLS(4), .ROW_BITS(1), .PWM_BITS(2), .PIX_BITS(16), .CLK_DIV(1)) dut (
    .clock(clock),
    .resetn(resetn),
    .enable(enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .bus(bus),
    .frame_start(frame_start),
    .busy(busy)
  );
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) bus.ram_rdata <= mem[bus.ram_raddr];
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string w);
    chk({w, " oe"}, 32'(bus.hub_oe), 32'd1);
    chk({w, " busy"}, 32'(busy), 32'd0);
    chk({w, " clk"}, 32'(bus.hub_clk), 32'd0);
    chk({w, " lat"}, 32'(bus.hub_lat), 32'd0);
    chk({w, " addr"}, 32'(bus.hub_addr), 32'd0);
    chk({w, " rgb"}, 32'(bus.hub_rgb), 32'd0);
    chk({w, " raddr"}, 32'(bus.ram_raddr), 32'd0);
    chk({w, " fs"}, 32'(frame_start), 32'd0);
  endtask
  initial begin
    n_cmp = 0;
    n_bad = 0;
    // upper R=3, lower B=1; junk in unused MSBs must not matter
    for (int i = 0; i < 8; i++) mem[i] = {16'hFFB0, 16'hC001};
    resetn = 1'b0;
    enable = 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
    brightness = 3'd4;
`endif
    tick();
    tick();
    chk_reset("por");
    resetn = 1'b1;
    enable = 1'b1;
    tick();
    chk("pre fs", 32'(frame_start), 32'd1);
    tick();
    tick();
    tick();
    resetn = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    chk_reset("midshift");
    resetn = 1'b1;
    tick();
    chk("idle busy", 32'(busy), 32'd0);
    enable = 1'b1;
    for (int t = 0; t <= 80; t++) begin
      tick();
      k = t / 11;
      c = t % 11;
      rw = k % 2;
      pw = (k / 2) % 3;
      chk($sformatf("clk t%0d", t), 32'(bus.hub_clk), 32'(c >= 2 && c <= 8 && c % 2 == 0));
      chk($sformatf("lat t%0d", t), 32'(bus.hub_lat), 32'(c == 10));
      chk($sformatf("oe t%0d", t), 32'(bus.hub_oe), 32'(c >= 9 || t < 11));
      chk($sformatf("raddr t%0d", t), 32'(bus.ram_raddr), 32'(rw * 4 + (c < 2 ? 0 : (c / 2 > 3 ? 3 : c / 2))));
      chk($sformatf("fs t%0d", t), 32'(frame_start), 32'(c == 0 && k % 6 == 0));
      chk($sformatf("busy t%0d", t), 32'(busy), 32'd1);
      chk($sformatf("addr t%0d", t), 32'(bus.hub_addr), 32'(c == 10 ? rw : (k == 0 ? 0 : (k - 1) % 2)));
      if (c >= 2) chk($sformatf("rgb t%0d", t), 32'(bus.hub_rgb), pw == 0 ? 32'h21 : 32'h20);
    end
    enable = 1'b0;
    lats = 0;
    idle_at = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      lats += int'(bus.hub_lat);
      if (!busy && idle_at == 0) idle_at = i;
    end
    chk("stop lat pulses", 32'(lats), 32'd1);
    chk("stop idle cycle", 32'(idle_at), 32'd8);
    chk("stop oe", 32'(bus.hub_oe), 32'd1);
    chk("stop busy", 32'(busy), 32'd0);
`ifdef HUB75_BRIGHTNESS_EN
    brightness = 3'd2;
    enable = 1'b1;
    lows = 0;
    for (int t = 0; t <= 32; t++) begin
      tick();
      k = t / 11;
      c = t % 11;
      chk($sformatf("br2 oe t%0d", t), 32'(bus.hub_oe), 32'(!(k >= 1 && c <= 4)));
      if (k == 1) lows += int'(!bus.hub_oe);
    end
    chk("br2 on cycles", 32'(lows), 32'd5);
    enable = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("br idle", 32'(busy), 32'd0);
    brightness = 3'd0;
    enable = 1'b1;
    for (int t = 0; t <= 32; t++) begin
      tick();
      chk($sformatf("br0 oe t%0d", t), 32'(bus.hub_oe), 32'd1);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
